// File: rtl/lpf_sched_pkg.sv
// Shared types and constants for the LPF channel scheduler.
// Contents:
//   FRAC      - fractional bits carried in the accumulator
//   SAMPLE_W  - signed sample width
//   ACC_W     - accumulator width (SAMPLE_W + FRAC)
//   CH_W      - width of the channel tag held in a stage register (up to 16 channels)
//   sample_t  - signed sample type
//   acc_t     - signed accumulator type
//   stage_t   - registered grant: {valid, ch, x, x_prev, y}
//   scale_sample() - lifts a sample into accumulator format ({x, FRAC zeros})
package lpf_sched_pkg;

  localparam int FRAC     = 32;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = SAMPLE_W + FRAC;
  localparam int CH_W     = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    sample_t         x;
    acc_t            x_prev;
    acc_t            y;
  } stage_t;

  function automatic acc_t scale_sample(input sample_t x);
    return {x, {FRAC{1'b0}}};
  endfunction

endpackage

// File: rtl/lpf_rr_arbiter.sv
// Round-robin arbiter for the LPF channel scheduler.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   req          - per-channel pending requests
//   skip         - channels that must not be granted this cycle
//   enable       - global grant enable
//   grant        - one-hot grant
//   grant_idx    - index of the granted channel
//   grant_valid  - a grant was issued this cycle
// The pointer holds the last granted index; the search starts one past it.
module lpf_rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         skip,
  input  logic                   enable,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] grant_idx,
  output logic                   grant_valid
);

  localparam int CW = $clog2(NCH);

  logic [CW-1:0] last;

  always_comb begin
    int            cand;
    logic [CW-1:0] cidx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cidx        = '0;
    if (enable) begin
      for (int off = 1; off <= NCH; off++) begin
        cand = int'(last) + off;
        if (cand >= NCH) cand = cand - NCH;
        cidx = CW'(cand);
        if (!grant_valid && req[cidx] && !skip[cidx]) begin
          grant_valid = 1'b1;
          grant_idx   = cidx;
          grant[cidx] = 1'b1;
        end
      end
    end
  end

  // Reset value NCH-1 makes channel 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset)            last <= CW'(NCH - 1);
    else if (grant_valid) last <= grant_idx;
  end

endmodule

// File: rtl/lpf_channel_scheduler.sv
// Time-multiplexed single-pole IIR low-pass engine shared by NCH channels.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   enable      - global grant enable (capture continues when low)
//   ch_clear    - per-channel state clear pulse
//   din         - packed samples, channel i in [DW*i +: DW]
//   din_valid   - per-channel sample strobe
//   dout        - filtered sample, dout_ch its channel, dout_valid its strobe
//   overrun     - sticky per-channel flag: a pending sample was replaced
//   busy        - any pending sample or an update in flight
// Optional feature macro: LPF_SCHED_PRELOAD_EN (first update after reset or
// ch_clear loads the state with the sample itself, so dout starts at x).
// DW/AW must match SAMPLE_W/ACC_W of lpf_sched_pkg.
module lpf_channel_scheduler
  import lpf_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int K   = 26,
  parameter int DW  = SAMPLE_W,
  parameter int AW  = ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH-1:0]         ch_clear,
  input  logic [NCH*DW-1:0]      din,
  input  logic [NCH-1:0]         din_valid,
  output logic signed [DW-1:0]   dout,
  output logic [$clog2(NCH)-1:0] dout_ch,
  output logic                   dout_valid,
  output logic [NCH-1:0]         overrun,
  output logic                   busy
);

  localparam int CW = $clog2(NCH);

  logic [NCH-1:0] pend;
  sample_t        pend_x [NCH];
  acc_t           x_prev [NCH];
  acc_t           y      [NCH];
  stage_t         s2;

  logic [NCH-1:0] s2_hit;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  grant_idx;
  logic           grant_valid;
  logic           grant_live;
  logic           wb_en;
  acc_t           w1;
  acc_t           w4;
  acc_t           y_new;
  sample_t        dout_next;

`ifdef LPF_SCHED_PRELOAD_EN
  logic [NCH-1:0] fresh;
`endif

  // Channel currently being computed; it is masked from arbitration because
  // its state is only written back at the end of this cycle.
  always_comb begin
    s2_hit = '0;
    for (int i = 0; i < NCH; i++) s2_hit[i] = s2.valid && (s2.ch == CH_W'(i));
  end

  lpf_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (pend),
    .skip       (s2_hit),
    .enable     (enable),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  assign grant_live = grant_valid && !ch_clear[grant_idx];

  always_comb begin
    w1        = scale_sample(s2.x);
    w4        = (w1 + s2.x_prev) >>> K;
    y_new     = w4 + s2.y - (s2.y >>> (K - 1));
    dout_next = y_new[AW-1 -: DW];
`ifdef LPF_SCHED_PRELOAD_EN
    if (|(fresh & s2_hit)) begin
      y_new     = w1;
      dout_next = s2.x;
    end
`endif
    wb_en = s2.valid && !(|(ch_clear & s2_hit));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      overrun    <= '0;
      s2         <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend_x[i] <= '0;
        x_prev[i] <= '0;
        y[i]      <= '0;
      end
    end else begin
      s2.valid   <= grant_live;
      s2.ch      <= CH_W'(grant_idx);
      s2.x       <= pend_x[grant_idx];
      s2.x_prev  <= x_prev[grant_idx];
      s2.y       <= y[grant_idx];
      dout_valid <= wb_en;
      if (wb_en) begin
        dout    <= dout_next;
        dout_ch <= s2.ch[CW-1:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_clear[i]) begin
          x_prev[i] <= '0;
          y[i]      <= '0;
        end else if (wb_en && s2_hit[i]) begin
          x_prev[i] <= w1;
          y[i]      <= y_new;
        end
        // A sample arriving on the cycle its predecessor is granted is not
        // an overrun: the old one has just left for the engine.
        if (din_valid[i]) begin
          pend_x[i] <= din[DW*i +: DW];
          pend[i]   <= 1'b1;
          if (pend[i] && !grant[i]) overrun[i] <= 1'b1;
        end else if (ch_clear[i] || grant[i]) begin
          pend[i] <= 1'b0;
        end
        if (ch_clear[i]) overrun[i] <= 1'b0;
      end
    end
  end

`ifdef LPF_SCHED_PRELOAD_EN
  always_ff @(posedge clk) begin
    if (reset) fresh <= '1;
    else       fresh <= (fresh & ~({NCH{wb_en}} & s2_hit)) | ch_clear;
  end
`endif

  // The grant stage is combinational off pend, so pend covers it.
  assign busy = (|pend) || s2.valid;

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
module tb_lpf_channel_scheduler;

  localparam int NCH = 4;
  localparam int K   = 8;
  localparam int DW  = 16;
  localparam int AW  = 48;
  localparam int CW  = $clog2(NCH);

  logic                 clk       = 1'b0;
  logic                 reset     = 1'b1;
  logic                 enable    = 1'b0;
  logic [NCH-1:0]       ch_clear  = '0;
  logic [NCH-1:0]       din_valid = '0;
  logic [NCH*DW-1:0]    din       = '0;
  logic signed [DW-1:0] dout;
  logic [CW-1:0]        dout_ch;
  logic                 dout_valid;
  logic [NCH-1:0]       overrun;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-channel previous sample and output accumulator,
  // pending sample table, RR pointer and the single in-flight update.
  bit                   m_pend  [NCH];
  int                   m_px    [NCH];
  int                   m_xl    [NCH];
  logic signed [AW-1:0] m_y     [NCH];
  bit                   m_fresh [NCH];
  logic [NCH-1:0]       m_ovr;
  int                   m_last;
  bit                   m_s2v;
  int                   m_s2ch;
  int                   m_s2x;
  bit                   m_busy;
  bit                   e_v;
  int                   e_ch;
  int                   e_dout;

  int prev0, last0, cnt2;

  always #5 clk = ~clk;

  lpf_channel_scheduler #(.NCH(NCH), .K(K), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_clear  (ch_clear),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_ch   (dout_ch),
    .dout_valid(dout_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  function automatic logic signed [AW-1:0] nextY(input int x, input int xl,
                                                 input logic signed [AW-1:0] yo);
    longint               s;
    logic signed [AW-1:0] t;
    s = (longint'(x) + longint'(xl)) <<< 32;
    t = s[AW-1:0];
    return (t >>> K) + yo - (yo >>> (K - 1));
  endfunction

  function automatic int topOf(input logic signed [AW-1:0] v);
    logic signed [DW-1:0] h;
    h = v[AW-1 -: DW];
    return int'(h);
  endfunction

  function automatic logic [NCH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NCH*DW-1:0] p;
    p = '0;
    p[0*DW +: DW] = DW'(a);
    p[1*DW +: DW] = DW'(b);
    p[2*DW +: DW] = DW'(c);
    p[3*DW +: DW] = DW'(d);
    return p;
  endfunction

  function automatic logic [NCH*DW-1:0] randDin();
    return pack4(int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 8000,
                 int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 8000);
  endfunction

  task automatic checkVal(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input logic [NCH-1:0] clr,
                               input logic [NCH-1:0] dv, input logic [NCH*DW-1:0] d);
    reset     = rst;
    enable    = en;
    ch_clear  = clr;
    din_valid = dv;
    din       = d;
  endtask

  // Advances the model by one clock edge using the inputs now applied.
  task automatic modelStep();
    int                   w, c;
    bit                   g, ns2v;
    int                   ns2ch, ns2x;
    logic signed [AW-1:0] yn;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = 0; m_px[i] = 0; m_xl[i] = 0; m_y[i] = '0; m_fresh[i] = 1;
      end
      m_ovr = '0; m_last = NCH - 1; m_s2v = 0; m_s2ch = 0; m_s2x = 0;
      e_v = 0; e_ch = 0; e_dout = 0; m_busy = 0;
      return;
    end
    e_v = 0;
    if (m_s2v && !ch_clear[m_s2ch]) begin
      yn = nextY(m_s2x, m_xl[m_s2ch], m_y[m_s2ch]);
`ifdef LPF_SCHED_PRELOAD_EN
      if (m_fresh[m_s2ch]) yn = AW'(longint'(m_s2x) <<< 32);
`endif
      m_y[m_s2ch] = yn; m_xl[m_s2ch] = m_s2x; m_fresh[m_s2ch] = 0;
      e_v = 1; e_ch = m_s2ch; e_dout = topOf(yn);
    end
    g = 0; w = 0; c = 0;
    if (enable) begin
      for (int off = 1; off <= NCH; off++) begin
        c = (m_last + off) % NCH;
        if (!g && m_pend[c] && !(m_s2v && m_s2ch == c)) begin g = 1; w = c; end
      end
    end
    ns2v = 0; ns2ch = 0; ns2x = 0;
    if (g) begin
      m_last = w;
      if (!ch_clear[w]) begin ns2v = 1; ns2ch = w; ns2x = m_px[w]; end
    end
    for (int i = 0; i < NCH; i++) begin
      if (din_valid[i]) begin
        if (m_pend[i] && !(g && w == i)) m_ovr[i] = 1'b1;
        m_pend[i] = 1;
        m_px[i] = int'($signed(din[i*DW +: DW]));
      end else if (ch_clear[i] || (g && w == i)) begin
        m_pend[i] = 0;
      end
      if (ch_clear[i]) begin
        m_xl[i] = 0; m_y[i] = '0; m_ovr[i] = 1'b0; m_fresh[i] = 1;
      end
    end
    m_s2v = ns2v; m_s2ch = ns2ch; m_s2x = ns2x;
    m_busy = ns2v;
    for (int i = 0; i < NCH; i++) if (m_pend[i]) m_busy = 1;
  endtask

  task automatic checkOutput();
    checkVal("dout_valid", dout_valid, e_v);
    if (e_v) begin
      checkVal("dout", dout, e_dout);
      checkVal("dout_ch", dout_ch, e_ch);
    end
    checkVal("overrun", overrun, m_ovr);
    checkVal("busy", busy, m_busy);
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic trackRise();
    if (dout_valid && dout_ch == 0) begin
      checkVal("ch0_rising", (int'(dout) >= prev0) && (int'(dout) <= 1000), 1);
      prev0 = int'(dout);
      last0 = int'(dout);
    end
  endtask

  initial begin
    // Power-on reset, then random traffic so the later reset has work to discard.
    for (int i = 0; i < 2; i++) begin applyStimulus(1, 0, '0, '0, '0); cycle(); end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, ($urandom % 4) != 0, '0, NCH'($urandom), randDin());
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, '0, '1, randDin());
      cycle();
      checkVal("rst_dout", dout, 0);
      checkVal("rst_dout_ch", dout_ch, 0);
      checkVal("rst_dout_valid", dout_valid, 0);
      checkVal("rst_overrun", overrun, 0);
      checkVal("rst_busy", busy, 0);
    end

    // All channels in one cycle: results in n+3..n+6, tags 0..3.
    applyStimulus(0, 1, '0, 4'hF, pack4(100, 200, -300, 400)); cycle();
    applyStimulus(0, 1, '0, '0, '0); cycle(); cycle();
    for (int k = 0; k < NCH; k++) begin
      checkVal("all_ch_valid", dout_valid, 1);
      checkVal("all_ch_tag", dout_ch, k);
      checkVal("all_ch_overrun", overrun, 0);
      cycle();
    end
    for (int i = 0; i < 4; i++) cycle();

    // ch0 x=1000 every 8 cycles: three-cycle latency, rising output.
    prev0 = -32768; last0 = -32768;
    for (int s = 0; s < 4; s++) begin
      applyStimulus(0, 1, '0, 4'b0001, pack4(1000, 0, 0, 0)); cycle();
      applyStimulus(0, 1, '0, '0, '0); cycle(); cycle();
      checkVal("lat3_valid", dout_valid, 1);
      checkVal("lat3_ch", dout_ch, 0);
      trackRise();
      for (int i = 0; i < 5; i++) cycle();
    end
    // Keep feeding 1000 until the DC gain of one shows up exactly.
    for (int s = 0; s < 4000; s++) begin
      applyStimulus(0, 1, '0, 4'b0001, pack4(1000, 0, 0, 0)); cycle(); trackRise();
      applyStimulus(0, 1, '0, '0, '0); cycle(); trackRise();
    end
    for (int i = 0; i < 4; i++) begin cycle(); trackRise(); end
    checkVal("ch0_settled", last0, 1000);

    // enable low: second ch2 sample overwrites the first.
    applyStimulus(0, 0, '0, 4'b0100, pack4(0, 0, 5, 0)); cycle();
    applyStimulus(0, 0, '0, 4'b0100, pack4(0, 0, 7, 0)); cycle();
    checkVal("ovr_set", overrun[2], 1);
    applyStimulus(0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    checkVal("hold_busy", busy, 1);
    applyStimulus(0, 1, '0, '0, '0);
    cnt2 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (dout_valid && dout_ch == 2) cnt2++;
    end
    checkVal("ch2_once", cnt2, 1);
    applyStimulus(0, 1, 4'b0100, '0, '0); cycle();
    checkVal("ovr_cleared", overrun[2], 0);

    // ch_clear while ch1 is being computed suppresses its result and state.
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 1, '0, 4'b0010, pack4(0, 5000, 0, 0)); cycle();
      applyStimulus(0, 1, '0, '0, '0); cycle(); cycle(); cycle();
    end
    applyStimulus(0, 1, '0, 4'b0010, pack4(0, 5000, 0, 0)); cycle();
    applyStimulus(0, 1, '0, '0, '0); cycle();
    applyStimulus(0, 1, 4'b0010, '0, '0); cycle();
    checkVal("clr_no_valid", dout_valid, 0);
    applyStimulus(0, 1, '0, '0, '0); cycle(); cycle();
    applyStimulus(0, 1, '0, 4'b0010, pack4(0, 0, 0, 0)); cycle();
    applyStimulus(0, 1, '0, '0, '0); cycle(); cycle();
    checkVal("clr_zero_valid", dout_valid, 1);
    checkVal("clr_zero_ch", dout_ch, 1);
    checkVal("clr_zero_dout", dout, 0);
    cycle(); cycle();

`ifdef LPF_SCHED_PRELOAD_EN
    // Preload: after a clear the first result already equals the input.
    applyStimulus(0, 1, 4'b1000, '0, '0); cycle();
    for (int s = 0; s < 4; s++) begin
      applyStimulus(0, 1, '0, 4'b1000, pack4(0, 0, 0, -2000)); cycle();
      applyStimulus(0, 1, '0, '0, '0); cycle(); cycle();
      checkVal("preload_valid", dout_valid, 1);
      checkVal("preload_dout", dout, -2000);
      cycle();
    end
`endif

    // Random traffic with occasional clears, enable drops and one reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(i == 200 || i == 201, ($urandom % 4) != 0,
                    NCH'($urandom) & NCH'($urandom) & NCH'($urandom) & NCH'($urandom),
                    NCH'($urandom), randDin());
      cycle();
    end
    applyStimulus(0, 1, '0, '0, '0);
    for (int i = 0; i < 8; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
